// File: rtl/multi_xy_seq_if.sv
// Handshake bundle for multi_xy_seq: operand request channel plus product response channel.
interface multi_xy_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               signed_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output in_valid, x, y, signed_en, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, x, y, signed_en, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/multi_xy_seq.sv
// Sequential shift-add multiplier: sign-magnitude operands, one add per multiplier bit,
// valid/ready on both sides with output backpressure.
module multi_xy_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  multi_xy_seq_if.slave mul_if
);
  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;
  logic               negFlag_q;
  logic               outValid_q;

  logic [WIDTH-1:0]   absX_d;
  logic [WIDTH-1:0]   absY_d;
  logic               negFlag_d;
  logic [2*WIDTH-1:0] accSum_d;
  logic [2*WIDTH-1:0] product_d;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    absX_d    = mul_if.x;
    absY_d    = mul_if.y;
    if (mul_if.signed_en && mul_if.x[WIDTH-1]) absX_d = -mul_if.x;
    if (mul_if.signed_en && mul_if.y[WIDTH-1]) absY_d = -mul_if.y;
    negFlag_d = mul_if.signed_en & (mul_if.x[WIDTH-1] ^ mul_if.y[WIDTH-1]);
    accSum_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product_d = negFlag_q ? -accSum_d : accSum_d;
  end

  assign mul_if.in_ready  = (state_q == IDLE) && !rst;
  assign mul_if.out_valid = outValid_q;
  assign mul_if.result    = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      negFlag_q  <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_if.in_valid) begin
            acc_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, absX_d};
            mplier_q  <= absY_d;
            count_q   <= '0;
            negFlag_q <= negFlag_d;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q    <= accSum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          // Final iteration folds the sign back in while registering the product.
          if (count_q == LAST_ITER) begin
            result_q   <= product_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (mul_if.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_xy_seq.sv
// Scoreboard bench for multi_xy_seq: directed cases and random traffic on an 8-bit instance,
// plus random signed/unsigned traffic on a 16-bit instance.
module tb_multi_xy_seq;
  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst16;
  always #5 clk = ~clk;

  multi_xy_seq_if #(.WIDTH(W))   bus8 ();
  multi_xy_seq_if #(.WIDTH(W16)) bus16 ();

  multi_xy_seq #(.WIDTH(W))   dut8  (.clk(clk), .rst(rst),   .mul_if(bus8.slave));
  multi_xy_seq #(.WIDTH(W16)) dut16 (.clk(clk), .rst(rst16), .mul_if(bus16.slave));

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int readyMode  = 1;
  bit done16     = 1'b0;

  logic [63:0] exp8[$];
  int          acc8[$];
  logic [63:0] exp16[$];
  int          acc16[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: interpret operands as integers and multiply, then wrap to the product width.
  function automatic logic [63:0] refProduct(input logic [63:0] xv, input logic [63:0] yv,
                                             input bit s, input int width);
    longint      a;
    longint      b;
    logic [63:0] mask;
    a = longint'(xv);
    b = longint'(yv);
    if (s && xv[width-1]) a = a - (longint'(1) << width);
    if (s && yv[width-1]) b = b - (longint'(1) << width);
    mask = (64'd1 << (2 * width)) - 64'd1;
    return 64'(a * b) & mask;
  endfunction

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       bus8.out_ready = 1'b0;
      1:       bus8.out_ready = 1'b1;
      default: bus8.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    bus16.out_ready = ($urandom_range(0, 7) != 0);
  end

  // 8-bit monitor: latency, hold-under-backpressure, release and result ordering.
  logic        prevValid8 = 1'b0;
  logic        prevReady8 = 1'b0;
  logic [15:0] prevRes8   = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.out_valid && !prevValid8) begin
        if (acc8.size() == 0) checkOutput("unexpected out_valid", 64'd1, 64'd0);
        else checkOutput("latency", 64'(cycle - acc8.pop_front()), 64'(W));
      end
      if (bus8.out_valid) checkOutput("in_ready while busy", 64'(bus8.in_ready), 64'd0);
      if (prevValid8 && !prevReady8) begin
        checkOutput("hold out_valid", 64'(bus8.out_valid), 64'd1);
        checkOutput("hold result", 64'(bus8.result), 64'(prevRes8));
      end
      if (prevValid8 && prevReady8) begin
        checkOutput("out_valid drop", 64'(bus8.out_valid), 64'd0);
        checkOutput("in_ready return", 64'(bus8.in_ready), 64'd1);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (exp8.size() == 0) checkOutput("unexpected result", 64'd1, 64'd0);
        else checkOutput("result", 64'(bus8.result), exp8.pop_front());
      end
    end
    prevValid8 = bus8.out_valid;
    prevReady8 = bus8.out_ready;
    prevRes8   = bus8.result;
  end

  logic prevValid16 = 1'b0;
  always @(negedge clk) begin
    if (!rst16) begin
      if (bus16.out_valid && !prevValid16) begin
        if (acc16.size() == 0) checkOutput("w16 unexpected out_valid", 64'd1, 64'd0);
        else checkOutput("w16 latency", 64'(cycle - acc16.pop_front()), 64'(W16));
      end
      if (bus16.out_valid && bus16.out_ready) begin
        if (exp16.size() == 0) checkOutput("w16 unexpected result", 64'd1, 64'd0);
        else checkOutput("w16 result", 64'(bus16.result), exp16.pop_front());
      end
    end
    prevValid16 = bus16.out_valid;
  end

  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit s,
                               input logic [63:0] expected, output int acceptCycle);
    bit accepted;
    bus8.x         = xv;
    bus8.y         = yv;
    bus8.signed_en = s;
    bus8.in_valid  = 1'b1;
    accepted       = 1'b0;
    acceptCycle    = -1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (bus8.in_ready) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept timeout", 64'd0, 64'd1);
    else begin
      exp8.push_back(expected);
      acc8.push_back(cycle + 1);
      acceptCycle = cycle + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp8.size() != 0 || bus8.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drain timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit s,
                        input logic [63:0] expected);
    int a;
    applyStimulus(xv, yv, s, expected, a);
    bus8.in_valid = 1'b0;
    waitDrain();
  endtask

  initial begin
    int          a1;
    int          a2;
    int          a3;
    int          n;
    logic [W-1:0] xr;
    logic [W-1:0] yr;
    bit          sr;

    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.x         = '0;
    bus8.y         = '0;
    bus8.signed_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 64'(bus8.in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(bus8.out_valid), 64'd0);
    checkOutput("reset result", 64'(bus8.result), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1;

    runOne(8'd255, 8'd255, 1'b0, 64'hFE01);
    runOne(8'h80,  8'h80,  1'b1, 64'h4000);
    runOne(8'hFD,  8'h05,  1'b1, 64'hFFF1);
    runOne(8'h7F,  8'h80,  1'b1, 64'hC080);
    runOne(8'h00,  8'hFF,  1'b1, 64'h0000);
    runOne(8'hFD,  8'h05,  1'b0, 64'h04F1);

    // Backpressure with junk on the request side while busy.
    readyMode = 0;
    applyStimulus(8'd12, 8'd10, 1'b0, 64'd120, a1);
    repeat (W + 5) begin
      bus8.in_valid = 1'($urandom_range(0, 1));
      bus8.x        = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
    readyMode     = 1;
    waitDrain();

    applyStimulus(8'd200, 8'd3,   1'b0, refProduct(64'd200, 64'd3, 1'b0, W), a1);
    applyStimulus(8'hF9,  8'd9,   1'b1, refProduct(64'hF9, 64'd9, 1'b1, W), a2);
    applyStimulus(8'd100, 8'd100, 1'b1, refProduct(64'd100, 64'd100, 1'b1, W), a3);
    bus8.in_valid = 1'b0;
    checkOutput("initiation interval 1", 64'(a2 - a1), 64'(W + 2));
    checkOutput("initiation interval 2", 64'(a3 - a2), 64'(W + 2));
    waitDrain();

    applyStimulus(8'h55, 8'h33, 1'b0, refProduct(64'h55, 64'h33, 1'b0, W), a1);
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp8.delete();
    acc8.delete();
    @(negedge clk);
    checkOutput("in_ready under reset", 64'(bus8.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid after abort", 64'(bus8.out_valid), 64'd0);
    checkOutput("result after abort", 64'(bus8.result), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    runOne(8'd7, 8'd6, 1'b0, 64'd42);

    readyMode = 2;
    for (int t = 0; t < 300; t++) begin
      xr = 8'($urandom);
      yr = 8'($urandom);
      sr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) xr = 8'h80;
      if ($urandom_range(0, 9) == 0) yr = 8'h00;
      applyStimulus(xr, yr, sr, refProduct(64'(xr), 64'(yr), sr, W), a1);
      if ($urandom_range(0, 2) == 0) begin
        bus8.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bus8.in_valid = 1'b0;
    readyMode     = 1;
    waitDrain();

    n = 0;
    while ((!done16 || exp16.size() != 0) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) checkOutput("w16 completion timeout", 64'd0, 64'd1);
    checkOutput("w16 outstanding", 64'(exp16.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    bit            ok;
    logic [W16-1:0] xr;
    logic [W16-1:0] yr;
    bit            sr;

    rst16           = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.x         = '0;
    bus16.y         = '0;
    bus16.signed_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst16 = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      xr = 16'($urandom);
      yr = 16'($urandom);
      sr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) xr = 16'h8000;
      if ($urandom_range(0, 15) == 0) yr = 16'h0000;
      bus16.x         = xr;
      bus16.y         = yr;
      bus16.signed_en = sr;
      bus16.in_valid  = 1'b1;
      ok              = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (bus16.in_ready) ok = 1'b1;
      end
      if (!ok) checkOutput("w16 accept timeout", 64'd0, 64'd1);
      else begin
        exp16.push_back(refProduct(64'(xr), 64'(yr), sr, W16));
        acc16.push_back(cycle + 1);
      end
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) bus16.in_valid = 1'b0;
    end
    bus16.in_valid = 1'b0;
    done16         = 1'b1;
  end
endmodule
